vector_slice_pipe: RTL and testbench

//  Parametrised, registered successor of the fixed 8-bit vector splitter.
//  - Accepts a DATA_W-bit word over a valid/ready handshake and returns three results:
//    - a 1-bit select/parity result;
//    - a FIELD_W-bit slice at a run-time offset;
//    - the word either bit-reversed or passed through.
//  - Results appear one cycle after acceptance, with full throughput and a skid buffer.
//  - Sits between the input word source and downstream result consumers.

---
 rtl/vector_v_pkg.sv | 13 +
 rtl/vector_slice_core.sv | 33 +++
 rtl/vector_slice_pipe.sv | 92 +++++++++
 tb/tb_vector_slice_pipe.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_v_pkg.sv
// vector_v_pkg: shared mode encodings and default widths for the vector slice pipeline
//   MODE_SEL / MODE_PAR : in_mode[0] values (select bit / XOR parity for res1)
//   REV_OFF  / REV_ON   : in_mode[1] values (pass-through / bit-reverse for res3)
//   DEF_*               : default parameter widths
package vector_v_pkg;
   localparam logic MODE_SEL = 1'b0;
   localparam logic MODE_PAR = 1'b1;
   localparam logic REV_OFF = 1'b0;
   localparam logic REV_ON = 1'b1;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_FIELD_W = 4;
   localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/vector_slice_core.sv
// vector_slice_core: combinational result datapath for one word
//   data [DATA_W]  input word
//   off  [OFF_W]   bit offset for res1 select and res2 slice
//   mode [2]       [0] res1 select/parity, [1] res3 pass/reverse
//   res1 [1]       selected bit or XOR parity
//   res2 [FIELD_W] data[off +: FIELD_W], zero past the MSB
//   res3 [DATA_W]  data reversed or passed through
module vector_slice_core
   import vector_v_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int FIELD_W = DEF_FIELD_W,
   parameter int OFF_W = $clog2(DATA_W)
) (
   input logic [DATA_W-1:0] data,
   input logic [OFF_W-1:0] off,
   input logic [1:0] mode,
   output logic res1,
   output logic [FIELD_W-1:0] res2,
   output logic [DATA_W-1:0] res3
);
   logic [DATA_W-1:0] sh;
   logic [DATA_W-1:0] rev;
   // a logical right shift zero-fills, so offsets near or past the MSB read zeros
   assign sh = data >> off;
   assign res1 = (mode[0] == MODE_PAR) ? ^data : sh[0];
   assign res2 = sh[FIELD_W-1:0];
   always_comb begin
      rev = '0;
      for (int i = 0; i < DATA_W; i++) rev[i] = data[DATA_W-1-i];
   end
   assign res3 = (mode[1] == REV_ON) ? rev : data;
endmodule

// File: rtl/vector_slice_pipe.sv
// vector_slice_pipe: registered valid/ready wrapper around vector_slice_core with a 1-entry skid buffer
//   clk, rst            clock, asynchronous active-high reset
//   in_data/off/mode    input word, offset, mode (sampled on input transfer)
//   in_valid/in_ready   input handshake; in_ready = !skid_full
//   res1/res2/res3      registered results, valid with out_valid
//   out_valid/out_ready output handshake
//   word_cnt            count of accepted input words, wraps
module vector_slice_pipe
   import vector_v_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int FIELD_W = DEF_FIELD_W,
   parameter int OFF_W = $clog2(DATA_W),
   parameter int CNT_W = DEF_CNT_W
) (
   input logic clk,
   input logic rst,
   input logic [DATA_W-1:0] in_data,
   input logic [OFF_W-1:0] in_off,
   input logic [1:0] in_mode,
   input logic in_valid,
   output logic in_ready,
   output logic res1,
   output logic [FIELD_W-1:0] res2,
   output logic [DATA_W-1:0] res3,
   output logic out_valid,
   input logic out_ready,
   output logic [CNT_W-1:0] word_cnt
);
   logic c_res1;
   logic [FIELD_W-1:0] c_res2;
   logic [DATA_W-1:0] c_res3;
   logic skid_full;
   logic s_res1;
   logic [FIELD_W-1:0] s_res2;
   logic [DATA_W-1:0] s_res3;
   logic in_fire;
   logic out_free;

   vector_slice_core #(
      .DATA_W(DATA_W),
      .FIELD_W(FIELD_W),
      .OFF_W(OFF_W)
   ) u_core (
      .data(in_data),
      .off(in_off),
      .mode(in_mode),
      .res1(c_res1),
      .res2(c_res2),
      .res3(c_res3)
   );

   assign in_ready = !skid_full;
   assign in_fire = in_valid && in_ready;
   // output register can take a new entry when empty or being consumed this cycle
   assign out_free = !out_valid || out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         res1 <= 1'b0;
         res2 <= '0;
         res3 <= '0;
         skid_full <= 1'b0;
         s_res1 <= 1'b0;
         s_res2 <= '0;
         s_res3 <= '0;
         word_cnt <= '0;
      end else begin
         if (out_free) begin
            out_valid <= skid_full || in_fire;
            if (skid_full) begin
               res1 <= s_res1;
               res2 <= s_res2;
               res3 <= s_res3;
            end else if (in_fire) begin
               res1 <= c_res1;
               res2 <= c_res2;
               res3 <= c_res3;
            end
         end
         // the skid holds a word only when the output stage cannot take it directly
         skid_full <= out_free ? (skid_full && in_fire) : (skid_full || in_fire);
         if (in_fire && (skid_full || !out_free)) begin
            s_res1 <= c_res1;
            s_res2 <= c_res2;
            s_res3 <= c_res3;
         end
         word_cnt <= word_cnt + CNT_W'(in_fire);
      end
   end
endmodule

// File: tb/tb_vector_slice_pipe.sv
// tb_vector_slice_pipe: drives an 8-bit and a 12-bit instance in lockstep against a scoreboard model
module tb_vector_slice_pipe;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0;
   logic out_ready = 1'b1;
   logic [1:0] in_mode = 2'b00;
   logic [7:0] d8 = '0;
   logic [2:0] o8 = '0;
   logic [11:0] d12 = '0;
   logic [3:0] o12 = '0;
   logic rdy8, rdy12, ov8, ov12, r1_8, r1_12;
   logic [3:0] r2_8;
   logic [4:0] r2_12;
   logic [7:0] r3_8, cnt8, cnt12;
   logic [11:0] r3_12;

   typedef struct packed {
      logic r1;
      logic [4:0] r2;
      logic [11:0] r3;
   } exp_t;

   exp_t q8[$];
   exp_t q12[$];
   logic [7:0] ec8 = '0;
   logic [7:0] ec12 = '0;
   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   vector_slice_pipe #(.DATA_W(8), .FIELD_W(4), .OFF_W(3), .CNT_W(8)) dut8 (
      .clk(clk), .rst(rst), .in_data(d8), .in_off(o8), .in_mode(in_mode),
      .in_valid(in_valid), .in_ready(rdy8), .res1(r1_8), .res2(r2_8), .res3(r3_8),
      .out_valid(ov8), .out_ready(out_ready), .word_cnt(cnt8)
   );

   vector_slice_pipe #(.DATA_W(12), .FIELD_W(5), .OFF_W(4), .CNT_W(8)) dut12 (
      .clk(clk), .rst(rst), .in_data(d12), .in_off(o12), .in_mode(in_mode),
      .in_valid(in_valid), .in_ready(rdy12), .res1(r1_12), .res2(r2_12), .res3(r3_12),
      .out_valid(ov12), .out_ready(out_ready), .word_cnt(cnt12)
   );

   // results straight from the bit-level definitions, for a word of width w
   function automatic exp_t model(logic [11:0] d, int off, logic [1:0] m, int w, int fw);
      exp_t e;
      int ones;
      e = '0;
      ones = 0;
      for (int i = 0; i < w; i++) ones += int'(d[i]);
      e.r1 = m[0] ? ones % 2 == 1 : (off < w ? d[off] : 1'b0);
      for (int i = 0; i < fw; i++) e.r2[i] = (off + i < w) ? d[off+i] : 1'b0;
      for (int i = 0; i < w; i++) e.r3[i] = m[1] ? d[w-1-i] : d[i];
      return e;
   endfunction

   // one clock: score the output transfer and enqueue the input transfer due at the next edge
   task automatic step();
      exp_t e;
      bit f8, f12;
      f8 = in_valid && rdy8;
      f12 = in_valid && rdy12;
      if (ov8 && out_ready) begin
         n_cmp++;
         if (q8.size() == 0) begin
            n_bad++;
            $display("FAIL out8_order: got output %b/%h/%h, required none pending", r1_8, r2_8, r3_8);
         end else begin
            e = q8.pop_front();
            if ({r1_8, r2_8, r3_8} !== {e.r1, e.r2[3:0], e.r3[7:0]}) begin
               n_bad++;
               $display("FAIL out8_data: got %b/%h/%h, required %b/%h/%h", r1_8, r2_8, r3_8, e.r1, e.r2[3:0], e.r3[7:0]);
            end
         end
      end
      if (ov12 && out_ready) begin
         n_cmp++;
         if (q12.size() == 0) begin
            n_bad++;
            $display("FAIL out12_order: got output %b/%h/%h, required none pending", r1_12, r2_12, r3_12);
         end else begin
            e = q12.pop_front();
            if ({r1_12, r2_12, r3_12} !== {e.r1, e.r2, e.r3}) begin
               n_bad++;
               $display("FAIL out12_data: got %b/%h/%h, required %b/%h/%h", r1_12, r2_12, r3_12, e.r1, e.r2, e.r3);
            end
         end
      end
      if (f8) begin
         q8.push_back(model({4'h0, d8}, int'(o8), in_mode, 8, 4));
         ec8++;
      end
      if (f12) begin
         q12.push_back(model(d12, int'(o12), in_mode, 12, 5));
         ec12++;
      end
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (cnt8 !== ec8 || cnt12 !== ec12) begin
         n_bad++;
         $display("FAIL word_cnt: got %0d/%0d, required %0d/%0d", cnt8, cnt12, ec8, ec12);
      end
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      q8.delete();
      q12.delete();
      ec8 = '0;
      ec12 = '0;
   endtask

   task automatic send(logic [7:0] a, logic [2:0] oa, logic [11:0] b, logic [3:0] ob, logic [1:0] m);
      d8 = a;
      o8 = oa;
      d12 = b;
      o12 = ob;
      in_mode = m;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (3) step();
      n_cmp++;
      if (q8.size() != 0 || q12.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d/%0d words undelivered, required 0/0", q8.size(), q12.size());
      end
   endtask

   task automatic test_reset();
      apply_reset();
      n_cmp++;
      if ({ov8, r1_8, r2_8, r3_8, cnt8} !== '0 || rdy8 !== 1'b1) begin
         n_bad++;
         $display("FAIL reset8: got v=%b r=%b %h/%h cnt=%0d rdy=%b, required zeros rdy=1", ov8, r1_8, r2_8, r3_8, cnt8, rdy8);
      end
      n_cmp++;
      if ({ov12, r1_12, r2_12, r3_12, cnt12} !== '0 || rdy12 !== 1'b1) begin
         n_bad++;
         $display("FAIL reset12: got v=%b r=%b %h/%h cnt=%0d rdy=%b, required zeros rdy=1", ov12, r1_12, r2_12, r3_12, cnt12, rdy12);
      end
   endtask

   task automatic test_basic();
      send(8'hB4, 3'd2, 12'h0B4, 4'd2, 2'b10);
      n_cmp++;
      if ({ov8, r1_8, r2_8, r3_8, cnt8} !== {1'b1, 1'b1, 4'hD, 8'h2D, 8'd1}) begin
         n_bad++;
         $display("FAIL first_word: got v=%b r1=%b r2=%h r3=%h cnt=%0d, required 1 1 d 2d 1", ov8, r1_8, r2_8, r3_8, cnt8);
      end
      n_cmp++;
      if ({ov12, r2_12, r3_12} !== {1'b1, 5'h0D, 12'h2D0}) begin
         n_bad++;
         $display("FAIL first_word12: got v=%b r2=%h r3=%h, required 1 0d 2d0", ov12, r2_12, r3_12);
      end
      send(8'h07, 3'd0, 12'h007, 4'd0, 2'b01);
      n_cmp++;
      if ({r1_8, r3_8, r1_12, r3_12} !== {1'b1, 8'h07, 1'b1, 12'h007}) begin
         n_bad++;
         $display("FAIL parity: got %b/%h %b/%h, required 1/07 1/007", r1_8, r3_8, r1_12, r3_12);
      end
   endtask

   task automatic test_slice_edge();
      send(8'hF0, 3'd6, 12'hF00, 4'd10, 2'b00);
      n_cmp++;
      if ({r1_8, r2_8, r1_12, r2_12} !== {1'b1, 4'b0011, 1'b1, 5'b00011}) begin
         n_bad++;
         $display("FAIL slice_near_msb: got %b/%b %b/%b, required 1/0011 1/00011", r1_8, r2_8, r1_12, r2_12);
      end
      send(8'hF0, 3'd7, 12'hF00, 4'd11, 2'b00);
      n_cmp++;
      if ({r2_8, r2_12} !== {4'b0001, 5'b00001}) begin
         n_bad++;
         $display("FAIL slice_at_msb: got %b/%b, required 0001/00001", r2_8, r2_12);
      end
      send(8'hF0, 3'd7, 12'hFFF, 4'd13, 2'b00);
      n_cmp++;
      if ({r1_12, r2_12} !== {1'b0, 5'b00000}) begin
         n_bad++;
         $display("FAIL off_past_width: got %b/%b, required 0/00000", r1_12, r2_12);
      end
      drain();
   endtask

   task automatic test_stall();
      int sent, stall, drop_at;
      apply_reset();
      sent = 0;
      stall = 0;
      drop_at = -1;
      in_valid = 1'b1;
      d8 = 8'($urandom);
      o8 = 3'($urandom);
      d12 = 12'($urandom);
      o12 = 4'($urandom);
      in_mode = 2'($urandom);
      for (int g = 0; g < 100 && sent < 10; g++) begin
         bit f;
         out_ready = (stall == 0);
         if (stall > 0) stall--;
         if (!rdy8 && drop_at < 0) drop_at = sent;
         f = in_valid && rdy8;
         step();
         if (f) begin
            sent++;
            if (sent == 4) stall = 3;
            d8 = 8'($urandom);
            o8 = 3'($urandom);
            d12 = 12'($urandom);
            o12 = 4'($urandom);
            in_mode = 2'($urandom);
         end
      end
      in_valid = 1'b0;
      n_cmp++;
      if (sent != 10 || drop_at != 5) begin
         n_bad++;
         $display("FAIL stall: got %0d sent, in_ready drop after %0d, required 10 and 5", sent, drop_at);
      end
      drain();
      n_cmp++;
      if (cnt8 !== 8'd10 || cnt12 !== 8'd10) begin
         n_bad++;
         $display("FAIL stall_count: got %0d/%0d, required 10/10", cnt8, cnt12);
      end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      in_valid = 1'b1;
      for (int i = 0; i < 256; i++) begin
         d8 = 8'($urandom);
         o8 = 3'($urandom);
         d12 = 12'($urandom);
         o12 = 4'($urandom);
         in_mode = 2'($urandom);
         step();
      end
      in_valid = 1'b0;
      n_cmp++;
      if (cnt8 !== 8'd0 || cnt12 !== 8'd0) begin
         n_bad++;
         $display("FAIL wrap: got %0d/%0d, required 0/0", cnt8, cnt12);
      end
      drain();
   endtask

   task automatic test_reset_mid();
      apply_reset();
      out_ready = 1'b0;
      send(8'h5A, 3'd1, 12'hA5A, 4'd3, 2'b11);
      send(8'hC3, 3'd4, 12'h3C3, 4'd9, 2'b00);
      n_cmp++;
      if (rdy8 !== 1'b0 || ov8 !== 1'b1) begin
         n_bad++;
         $display("FAIL skid_full: got rdy=%b v=%b, required 0 1", rdy8, ov8);
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({ov8, r1_8, r2_8, r3_8, ov12, r1_12, r2_12, r3_12} !== '0) begin
         n_bad++;
         $display("FAIL reset_mid: got v=%b %b/%h/%h v=%b %b/%h/%h, required all 0", ov8, r1_8, r2_8, r3_8, ov12, r1_12, r2_12, r3_12);
      end
      q8.delete();
      q12.delete();
      ec8 = '0;
      ec12 = '0;
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (rdy8 !== 1'b1 || rdy12 !== 1'b1 || ov8 !== 1'b0 || cnt8 !== 8'd0) begin
         n_bad++;
         $display("FAIL reset_release: got rdy=%b/%b v=%b cnt=%0d, required 1/1 0 0", rdy8, rdy12, ov8, cnt8);
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_slice_edge();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
